instruction_dispatch: RTL and testbench

Consumes the 64-bit instruction words delivered by the SPI instruction receiver through its DATA/VALID/RD handshake. Each word is validated by sync byte and checksum, then decoded. Valid words update an internal configuration register file or issue acquisition start/stop controls. The block sits between the SPI receive path and the AD acquisition control logic, all in the CLK domain.

---
 rtl/instruction_dispatch_if.sv | 10 +
 rtl/instruction_dispatch.sv | 194 +++++++++++++++++++
 tb/tb_instruction_dispatch.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_dispatch_if.sv
// Instruction word handshake between the SPI receiver (master) and the
// dispatcher (slave): a level VALID with a held DATA word, acknowledged by RD.
interface instruction_dispatch_if;
  logic [63:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_RD;

  modport master (output IN_DATA, output IN_VALID, input IN_RD);
  modport slave  (input IN_DATA, input IN_VALID, output IN_RD);
endinterface

// File: rtl/instruction_dispatch.sv
// Validates and executes 64-bit instruction words: configuration register
// writes, acquisition start/stop/clear, with error and command bookkeeping.
module instruction_dispatch #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         NUM_REGS  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  instruction_dispatch_if.slave    bus,
  output logic [NUM_REGS*32-1:0]   REG_Q,
  output logic                     REG_WE,
  output logic [7:0]               REG_ADDR,
  output logic                     START_PULSE,
  output logic                     STOP_PULSE,
  output logic                     RUNNING,
  output logic [1:0]               ERR_CODE,
  output logic [15:0]              CMD_CNT,
  output logic [7:0]               ERR_CNT
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h03;
  localparam logic [7:0] OP_CLEAR = 8'h04;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_SYNC = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_OPAD = 2'd3;

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, WAIT_LOW} state_t;

  state_t      state_reg, state_next;
  logic [63:0] word_reg, word_next;
  logic [1:0]  err_chk_reg, err_chk_next;
  logic        in_rd_reg, in_rd_next;
  logic        reg_we_reg, reg_we_next;
  logic        start_reg, start_next;
  logic        stop_reg, stop_next;
  logic        running_reg, running_next;
  logic [7:0]  reg_addr_reg, reg_addr_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic [15:0] cmd_cnt_reg, cmd_cnt_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic        wr_en;
  logic        clear_all;
  logic [1:0]  check_code;

  logic [7:0]  w_sync, w_op, w_addr, w_csum, csum_calc;
  logic [31:0] w_value;
  logic        op_legal;

  assign w_sync    = word_reg[63:56];
  assign w_op      = word_reg[55:48];
  assign w_addr    = word_reg[47:40];
  assign w_value   = word_reg[39:8];
  assign w_csum    = word_reg[7:0];
  assign csum_calc = word_reg[63:56] ^ word_reg[55:48] ^ word_reg[47:40] ^
                     word_reg[39:32] ^ word_reg[31:24] ^ word_reg[23:16] ^
                     word_reg[15:8];

  always_comb begin
    op_legal = 1'b0;
    case (w_op)
      OP_WRITE: op_legal = ({1'b0, w_addr} < 9'(NUM_REGS));
      OP_START, OP_STOP, OP_CLEAR: op_legal = 1'b1;
      default:  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    if (w_sync != SYNC_BYTE)      check_code = ERR_SYNC;
    else if (csum_calc != w_csum) check_code = ERR_CSUM;
    else if (!op_legal)           check_code = ERR_OPAD;
    else                          check_code = ERR_OK;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      err_chk_reg  <= ERR_OK;
      in_rd_reg    <= 1'b0;
      reg_we_reg   <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
      running_reg  <= 1'b0;
      reg_addr_reg <= '0;
      err_code_reg <= ERR_OK;
      cmd_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      err_chk_reg  <= err_chk_next;
      in_rd_reg    <= in_rd_next;
      reg_we_reg   <= reg_we_next;
      start_reg    <= start_next;
      stop_reg     <= stop_next;
      running_reg  <= running_next;
      reg_addr_reg <= reg_addr_next;
      err_code_reg <= err_code_next;
      cmd_cnt_reg  <= cmd_cnt_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    err_chk_next  = err_chk_reg;
    in_rd_next    = 1'b0;
    reg_we_next   = 1'b0;
    start_next    = 1'b0;
    stop_next     = 1'b0;
    running_next  = running_reg;
    reg_addr_next = reg_addr_reg;
    err_code_next = err_code_reg;
    cmd_cnt_next  = cmd_cnt_reg;
    err_cnt_next  = err_cnt_reg;
    wr_en         = 1'b0;
    clear_all     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.IN_VALID) begin
          word_next  = bus.IN_DATA;
          in_rd_next = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        err_chk_next = check_code;
        state_next   = EXEC;
      end
      EXEC: begin
        err_code_next = err_chk_reg;
        if (err_chk_reg == ERR_OK) begin
          cmd_cnt_next = cmd_cnt_reg + 16'd1;
          case (w_op)
            OP_WRITE: begin
              wr_en         = 1'b1;
              reg_we_next   = 1'b1;
              reg_addr_next = w_addr;
            end
            OP_START: begin
              start_next   = 1'b1;
              running_next = 1'b1;
            end
            OP_STOP: begin
              stop_next    = 1'b1;
              running_next = 1'b0;
            end
            default: begin
              clear_all    = 1'b1;
              running_next = 1'b0;
            end
          endcase
        end else if (err_cnt_reg != 8'hFF) begin
          err_cnt_next = err_cnt_reg + 8'd1;
        end
        state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Hold off until VALID drops so a lingering word is never re-read.
        if (!bus.IN_VALID) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] q_reg;
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                              q_reg <= '0;
        else if (clear_all)                        q_reg <= '0;
        else if (wr_en && (w_addr == 8'(gi)))      q_reg <= w_value;
      end
      assign REG_Q[32*gi +: 32] = q_reg;
    end
  endgenerate

  assign bus.IN_RD   = in_rd_reg;
  assign REG_WE      = reg_we_reg;
  assign REG_ADDR    = reg_addr_reg;
  assign START_PULSE = start_reg;
  assign STOP_PULSE  = stop_reg;
  assign RUNNING     = running_reg;
  assign ERR_CODE    = err_code_reg;
  assign CMD_CNT     = cmd_cnt_reg;
  assign ERR_CNT     = err_cnt_reg;

endmodule

// File: tb/tb_instruction_dispatch.sv
// Directed bench for instruction_dispatch: acts as the SPI receiver and
// checks decode, error handling, handshake and reset behaviour.
module tb_instruction_dispatch;
  logic         CLK;
  logic         RESET_N;
  logic [255:0] REG_Q;
  logic         REG_WE;
  logic [7:0]   REG_ADDR;
  logic         START_PULSE;
  logic         STOP_PULSE;
  logic         RUNNING;
  logic [1:0]   ERR_CODE;
  logic [15:0]  CMD_CNT;
  logic [7:0]   ERR_CNT;

  int checks   = 0;
  int failures = 0;

  instruction_dispatch_if bus_if ();

  instruction_dispatch #(.SYNC_BYTE(8'hA5), .NUM_REGS(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus_if),
    .REG_Q(REG_Q), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
    .START_PULSE(START_PULSE), .STOP_PULSE(STOP_PULSE), .RUNNING(RUNNING),
    .ERR_CODE(ERR_CODE), .CMD_CNT(CMD_CNT), .ERR_CNT(ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse monitor, sampled on the falling edge.
  int cyc = 0;
  int rd_cnt = 0, we_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int rd_cyc = 0, we_cyc = 0, start_cyc = 0;
  logic multi_hot = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus_if.IN_RD === 1'b1) begin rd_cnt <= rd_cnt + 1; rd_cyc <= cyc; end
    if (REG_WE === 1'b1)       begin we_cnt <= we_cnt + 1; we_cyc <= cyc; end
    if (START_PULSE === 1'b1)  begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
    if (STOP_PULSE === 1'b1)   stop_cnt <= stop_cnt + 1;
    if ((32'(REG_WE) + 32'(START_PULSE) + 32'(STOP_PULSE)) > 1) multi_hot <= 1'b1;
  end

  task automatic wait_rd();
    int t = 0;
    while (bus_if.IN_RD !== 1'b1 && t < 10) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 10) begin
      checks++; failures++;
      $display("FAIL rd_timeout: IN_RD=%b after %0d cycles, required 1", bus_if.IN_RD, t);
    end
  endtask

  task automatic send_word(input logic [63:0] w, input int hold);
    @(negedge CLK);
    bus_if.IN_DATA  = w;
    bus_if.IN_VALID = 1'b1;
    wait_rd();
    repeat (hold) @(negedge CLK);
    bus_if.IN_VALID = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_reset();
    checks++;
    if (REG_Q !== '0 || REG_WE !== 1'b0 || START_PULSE !== 1'b0 || STOP_PULSE !== 1'b0 ||
        RUNNING !== 1'b0 || bus_if.IN_RD !== 1'b0 || REG_ADDR !== 8'd0 || ERR_CODE !== 2'd0 ||
        CMD_CNT !== 16'd0 || ERR_CNT !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: we=%b st=%b sp=%b run=%b rd=%b addr=%0d err=%0d cmd=%0d ecnt=%0d, required all 0",
               REG_WE, START_PULSE, STOP_PULSE, RUNNING, bus_if.IN_RD, REG_ADDR, ERR_CODE, CMD_CNT, ERR_CNT);
    end
  endtask

  task automatic test_reset_mid();
    int rd0;
    rd0 = rd_cnt;
    @(negedge CLK);
    bus_if.IN_DATA  = 64'hA501_0312_3456_78AF;
    bus_if.IN_VALID = 1'b1;
    wait_rd();
    RESET_N = 1'b0;  // FSM is in CHECK here
    #1;
    checks++;
    if (REG_Q !== '0 || bus_if.IN_RD !== 1'b0 || REG_WE !== 1'b0 || CMD_CNT !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: reg3=%h rd=%b we=%b cmd=%0d, required 0", REG_Q[127:96], bus_if.IN_RD, REG_WE, CMD_CNT);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (REG_Q !== '0 || REG_WE !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_regq: reg3=%h we=%b, required 0", REG_Q[127:96], REG_WE);
    end
    RESET_N = 1'b1;
    @(negedge CLK);
    wait_rd();
    bus_if.IN_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    checks++;
    if (rd_cnt - rd0 !== 2 || REG_Q[127:96] !== 32'h12345678 || CMD_CNT !== 16'd1) begin
      failures++;
      $display("FAIL reset_reread: rd=%0d reg3=%h cmd=%0d, required rd=2 reg3=12345678 cmd=1",
               rd_cnt - rd0, REG_Q[127:96], CMD_CNT);
    end
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_write();
    int rd0, we0;
    rd0 = rd_cnt; we0 = we_cnt;
    send_word(64'hA501_0312_3456_78AF, 0);
    checks++;
    if (rd_cnt - rd0 !== 1 || we_cnt - we0 !== 1) begin
      failures++;
      $display("FAIL write_pulses: rd=%0d we=%0d, required 1 1", rd_cnt - rd0, we_cnt - we0);
    end
    checks++;
    if (we_cyc - rd_cyc !== 2) begin
      failures++;
      $display("FAIL write_latency: we-rd=%0d cycles, required 2", we_cyc - rd_cyc);
    end
    checks++;
    if (REG_ADDR !== 8'd3 || REG_Q[127:96] !== 32'h12345678 || ERR_CODE !== 2'd0 || CMD_CNT !== 16'd1) begin
      failures++;
      $display("FAIL write_result: addr=%0d reg3=%h err=%0d cmd=%0d, required 3 12345678 0 1",
               REG_ADDR, REG_Q[127:96], ERR_CODE, CMD_CNT);
    end
  endtask

  task automatic test_start_stop();
    int s0, p0;
    s0 = start_cnt; p0 = stop_cnt;
    send_word(64'hA502_0000_0000_00A7, 0);
    checks++;
    if (start_cnt - s0 !== 1 || RUNNING !== 1'b1 || start_cyc - rd_cyc !== 2) begin
      failures++;
      $display("FAIL start: pulses=%0d run=%b lat=%0d, required 1 1 2", start_cnt - s0, RUNNING, start_cyc - rd_cyc);
    end
    send_word(64'hA503_0000_0000_00A6, 0);
    checks++;
    if (stop_cnt - p0 !== 1 || RUNNING !== 1'b0 || CMD_CNT !== 16'd3) begin
      failures++;
      $display("FAIL stop: pulses=%0d run=%b cmd=%0d, required 1 0 3", stop_cnt - p0, RUNNING, CMD_CNT);
    end
  endtask

  task automatic test_bad_checksum();
    int we0;
    we0 = we_cnt;
    send_word(64'hA501_0312_3456_7800, 0);
    checks++;
    if (ERR_CODE !== 2'd2 || ERR_CNT !== 8'd1 || we_cnt !== we0 ||
        REG_Q[127:96] !== 32'h12345678 || CMD_CNT !== 16'd3) begin
      failures++;
      $display("FAIL bad_checksum: err=%0d ecnt=%0d we=%0d reg3=%h cmd=%0d, required 2 1 0 12345678 3",
               ERR_CODE, ERR_CNT, we_cnt - we0, REG_Q[127:96], CMD_CNT);
    end
  endtask

  task automatic test_bad_addr_sync();
    int we0;
    we0 = we_cnt;
    send_word(64'hA501_0800_0000_01AD, 0);
    checks++;
    if (ERR_CODE !== 2'd3 || ERR_CNT !== 8'd2 || we_cnt !== we0) begin
      failures++;
      $display("FAIL bad_addr: err=%0d ecnt=%0d we=%0d, required 3 2 0", ERR_CODE, ERR_CNT, we_cnt - we0);
    end
    send_word(64'h5A01_0312_3456_78AF, 0);
    checks++;
    if (ERR_CODE !== 2'd1 || ERR_CNT !== 8'd3 || CMD_CNT !== 16'd3) begin
      failures++;
      $display("FAIL bad_sync: err=%0d ecnt=%0d cmd=%0d, required 1 3 3", ERR_CODE, ERR_CNT, CMD_CNT);
    end
  endtask

  task automatic test_handshake();
    int rd0, we0;
    rd0 = rd_cnt; we0 = we_cnt;
    send_word(64'hA501_0212_3456_78AE, 10);
    checks++;
    if (rd_cnt - rd0 !== 1 || we_cnt - we0 !== 1 || REG_Q[95:64] !== 32'h12345678 || ERR_CODE !== 2'd0) begin
      failures++;
      $display("FAIL handshake_hold: rd=%0d we=%0d reg2=%h err=%0d, required 1 1 12345678 0",
               rd_cnt - rd0, we_cnt - we0, REG_Q[95:64], ERR_CODE);
    end
    send_word(64'hA501_01DE_ADBE_EF87, 0);
    checks++;
    if (rd_cnt - rd0 !== 2 || REG_Q[63:32] !== 32'hDEADBEEF || REG_ADDR !== 8'd1 || CMD_CNT !== 16'd5) begin
      failures++;
      $display("FAIL handshake_next: rd=%0d reg1=%h addr=%0d cmd=%0d, required 2 deadbeef 1 5",
               rd_cnt - rd0, REG_Q[63:32], REG_ADDR, CMD_CNT);
    end
  endtask

  task automatic test_clear();
    int we0, p0;
    send_word(64'hA502_0000_0000_00A7, 0);
    checks++;
    if (RUNNING !== 1'b1 || REG_Q === '0) begin
      failures++;
      $display("FAIL clear_setup: run=%b reg3=%h, required run=1 and nonzero registers", RUNNING, REG_Q[127:96]);
    end
    we0 = we_cnt; p0 = stop_cnt;
    send_word(64'hA504_0000_0000_00A1, 0);
    checks++;
    if (REG_Q !== '0 || RUNNING !== 1'b0 || we_cnt !== we0 || stop_cnt !== p0 ||
        CMD_CNT !== 16'd7 || ERR_CODE !== 2'd0) begin
      failures++;
      $display("FAIL clear: reg3=%h reg1=%h run=%b we=%0d stop=%0d cmd=%0d err=%0d, required 0 0 0 0 0 7 0",
               REG_Q[127:96], REG_Q[63:32], RUNNING, we_cnt - we0, stop_cnt - p0, CMD_CNT, ERR_CODE);
    end
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 256; i++) begin
      send_word(64'hA502_0000_0000_0000, 0);
      if (i == 250) begin
        checks++;
        if (ERR_CNT !== 8'd254) begin
          failures++;
          $display("FAIL err_cnt_254: ERR_CNT=%0d, required 254", ERR_CNT);
        end
      end
      if (i == 251) begin
        checks++;
        if (ERR_CNT !== 8'd255) begin
          failures++;
          $display("FAIL err_cnt_255: ERR_CNT=%0d, required 255", ERR_CNT);
        end
      end
    end
    checks++;
    if (ERR_CNT !== 8'd255 || ERR_CODE !== 2'd2 || CMD_CNT !== 16'd7 || RUNNING !== 1'b0) begin
      failures++;
      $display("FAIL err_saturate: ecnt=%0d err=%0d cmd=%0d run=%b, required 255 2 7 0",
               ERR_CNT, ERR_CODE, CMD_CNT, RUNNING);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (multi_hot !== 1'b0) begin
      failures++;
      $display("FAIL pulse_exclusive: overlap seen=%b, required 0", multi_hot);
    end
  endtask

  initial begin
    RESET_N         = 1'b0;
    bus_if.IN_DATA  = '0;
    bus_if.IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    test_reset();
    test_reset_mid();
    test_reset();
    test_write();
    test_start_stop();
    test_bad_checksum();
    test_bad_addr_sync();
    test_handshake();
    test_clear();
    test_err_saturation();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
